// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - load/store responder over a word-organised data RAM with programmable wait latency
// Optional misaligned-access trap: define MEM_MISALIGN_TRAP_EN.
module data_mem_responder #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic        iMemRd,
    input  logic        iMemWr,
    input  logic [2:0]  iFunct3,
    input  logic [31:0] iAddr,
    input  logic [31:0] iWrData,
    output logic [31:0] oRdData,
    output logic        oStall,
    output logic        oDone,
    output logic        oMisalign
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LAST = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic [2:0]  f3_q;
    logic        wr_q;
    logic [31:0] rd_q;
    logic        mis_q;

    logic [31:0] mem [2**ADDR_W];

    logic        req;
    logic        in_idle;
    logic        enter_done;
    logic [31:0] acc_addr;
    logic [31:0] acc_data;
    logic [2:0]  acc_f3;
    logic        acc_wr;
    logic        is_b;
    logic        is_h;
    logic        trap;
    logic [1:0]  eff_lo;
    logic [ADDR_W-1:0] idx;
    logic [31:0] word_old;
    logic [31:0] word_sh;
    logic [31:0] load_val;
    logic [3:0]  be;
    logic [31:0] wdata_rep;
    logic [31:0] word_new;
    logic        unused_addr;

    assign req     = iMemRd | iMemWr;
    assign in_idle = (state_q == S_IDLE);

    // With WAIT_CYCLES=0 the access completes on the latching edge, so it must see the live inputs.
    assign acc_addr = in_idle ? iAddr   : addr_q;
    assign acc_data = in_idle ? iWrData : data_q;
    assign acc_f3   = in_idle ? iFunct3 : f3_q;
    assign acc_wr   = in_idle ? iMemWr  : wr_q;

    assign is_b = (acc_f3 == 3'b000) || (acc_f3 == 3'b100);
    assign is_h = (acc_f3 == 3'b001) || (acc_f3 == 3'b101);

`ifdef MEM_MISALIGN_TRAP_EN
    assign trap   = (is_h && acc_addr[0]) || (!is_b && !is_h && (acc_addr[1:0] != 2'b00));
    assign eff_lo = acc_addr[1:0];
`else
    assign trap   = 1'b0;
    assign eff_lo = is_b ? acc_addr[1:0] : (is_h ? {acc_addr[1], 1'b0} : 2'b00);
`endif

    assign idx         = acc_addr[ADDR_W+1:2];
    assign unused_addr = ^acc_addr[31:ADDR_W+2];
    assign word_old    = mem[idx];
    assign word_sh     = word_old >> {eff_lo, 3'b000};

    always_comb begin
        load_val = word_old;
        if (is_b) begin
            load_val = acc_f3[2] ? {24'd0, word_sh[7:0]} : {{24{word_sh[7]}}, word_sh[7:0]};
        end else if (is_h) begin
            load_val = acc_f3[2] ? {16'd0, word_sh[15:0]} : {{16{word_sh[15]}}, word_sh[15:0]};
        end
    end

    // Replicating the store data puts the right bytes on every candidate lane; be picks which ones land.
    always_comb begin
        be        = 4'b1111;
        wdata_rep = acc_data;
        if (is_b) begin
            be        = 4'b0001 << eff_lo;
            wdata_rep = {4{acc_data[7:0]}};
        end else if (is_h) begin
            be        = 4'b0011 << eff_lo;
            wdata_rep = {2{acc_data[15:0]}};
        end
        for (int i = 0; i < 4; i++) begin
            word_new[8*i +: 8] = be[i] ? wdata_rep[8*i +: 8] : word_old[8*i +: 8];
        end
    end

    assign enter_done = (state_d == S_DONE) && !iRst;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        oStall  = 1'b0;
        oDone   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    oStall  = 1'b1;
                    cnt_d   = 4'd0;
                    state_d = (WAIT_CYCLES == 0) ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                oStall = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = 4'd0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_DONE: begin
                oDone   = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            rd_q    <= 32'd0;
            mis_q   <= 1'b0;
            addr_q  <= 32'd0;
            data_q  <= 32'd0;
            f3_q    <= 3'd0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (in_idle && req) begin
                addr_q <= iAddr;
                data_q <= iWrData;
                f3_q   <= iFunct3;
                wr_q   <= iMemWr;
            end
            mis_q <= enter_done && trap;
            if (enter_done && !acc_wr) begin
                rd_q <= trap ? 32'd0 : load_val;
            end
        end
    end

    always_ff @(posedge iClk) begin
        if (enter_done && acc_wr && !trap) begin
            mem[idx] <= word_new;
        end
    end

    assign oRdData   = rd_q;
    assign oMisalign = mis_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - directed self-checking bench for data_mem_responder
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_rd;
    logic        mem_wr;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        stall;
    logic        done;
    logic        misalign;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] last_rd;
    logic        last_mis;

    always #5 clk = ~clk;

    data_mem_responder #(.ADDR_W(10), .WAIT_CYCLES(2)) dut (
        .iClk      (clk),
        .iRst      (rst),
        .iMemRd    (mem_rd),
        .iMemWr    (mem_wr),
        .iFunct3   (funct3),
        .iAddr     (addr),
        .iWrData   (wr_data),
        .oRdData   (rd_data),
        .oStall    (stall),
        .oDone     (done),
        .oMisalign (misalign)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Drives one request and holds it until the done pulse; expects 3 stall cycles (WAIT_CYCLES=2).
    task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] d, input string tag);
        int stalls;
        bit seen;
        stalls = 0;
        seen   = 1'b0;
        @(negedge clk);
        mem_rd  = rd;
        mem_wr  = wr;
        funct3  = f3;
        addr    = a;
        wr_data = d;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (stall) stalls++;
            @(negedge clk);
        end
        chk({tag, " done"}, 32'(seen), 32'd1);
        chk({tag, " stalls"}, 32'(stalls), 32'd3);
        chk({tag, " stall_in_done"}, 32'(stall), 32'd0);
        last_rd  = rd_data;
        last_mis = misalign;
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        @(negedge clk);
        #1;
        chk({tag, " done_pulse"}, 32'(done), 32'd0);
        chk({tag, " rd_held"}, rd_data, last_rd);
    endtask

    initial begin
        rst     = 1'b1;
        mem_rd  = 1'b0;
        mem_wr  = 1'b0;
        funct3  = 3'b010;
        addr    = 32'd0;
        wr_data = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst stall", 32'(stall), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst rdata", rd_data, 32'd0);
        chk("rst misalign", 32'(misalign), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            chk("idle stall", 32'(stall), 32'd0);
            chk("idle done", 32'(done), 32'd0);
            chk("idle rdata", rd_data, 32'd0);
        end

        access(1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, "sw10");
        chk("sw10 rdata_unchanged", last_rd, 32'd0);
        access(1'b1, 1'b0, 3'b010, 32'h10, 32'd0, "lw10");
        chk("lw10 data", last_rd, 32'hDEADBEEF);
        chk("lw10 misalign", 32'(last_mis), 32'd0);

        access(1'b1, 1'b0, 3'b000, 32'h13, 32'd0, "lb13");
        chk("lb13 data", last_rd, 32'hFFFFFFDE);
        access(1'b1, 1'b0, 3'b100, 32'h13, 32'd0, "lbu13");
        chk("lbu13 data", last_rd, 32'h000000DE);
        access(1'b1, 1'b0, 3'b001, 32'h10, 32'd0, "lh10");
        chk("lh10 data", last_rd, 32'hFFFFBEEF);
        access(1'b1, 1'b0, 3'b101, 32'h12, 32'd0, "lhu12");
        chk("lhu12 data", last_rd, 32'h0000DEAD);

        access(1'b0, 1'b1, 3'b000, 32'h11, 32'hFFFFFF55, "sb11");
        access(1'b1, 1'b0, 3'b010, 32'h10, 32'd0, "lw10b");
        chk("lw10b data", last_rd, 32'hDEAD55EF);
        access(1'b1, 1'b0, 3'b010, 32'h1010, 32'd0, "lw_alias");
        chk("lw_alias data", last_rd, 32'hDEAD55EF);

        access(1'b0, 1'b1, 3'b010, 32'h20, 32'hCAFEF00D, "sw20");
        @(negedge clk);
        mem_wr  = 1'b1;
        funct3  = 3'b010;
        addr    = 32'h20;
        wr_data = 32'h12345678;
        @(negedge clk);
        #1;
        chk("rstmid stall_wait", 32'(stall), 32'd1);
        rst    = 1'b1;
        mem_wr = 1'b0;
        @(negedge clk);
        #1;
        chk("rstmid stall", 32'(stall), 32'd0);
        chk("rstmid done", 32'(done), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("rstmid done2", 32'(done), 32'd0);
        chk("rstmid stall2", 32'(stall), 32'd0);
        access(1'b1, 1'b0, 3'b010, 32'h20, 32'd0, "lw20");
        chk("lw20 data", last_rd, 32'hCAFEF00D);

        access(1'b1, 1'b0, 3'b010, 32'h22, 32'd0, "lw22");
`ifdef MEM_MISALIGN_TRAP_EN
        chk("lw22 data", last_rd, 32'd0);
        chk("lw22 misalign", 32'(last_mis), 32'd1);
`else
        chk("lw22 data", last_rd, 32'hCAFEF00D);
        chk("lw22 misalign", 32'(last_mis), 32'd0);
`endif
        access(1'b1, 1'b1, 3'b010, 32'h30, 32'h11223344, "swrd30");
`ifdef MEM_MISALIGN_TRAP_EN
        chk("swrd30 rdata_unchanged", last_rd, 32'd0);
`else
        chk("swrd30 rdata_unchanged", last_rd, 32'hCAFEF00D);
`endif
        access(1'b1, 1'b0, 3'b010, 32'h30, 32'd0, "lw30");
        chk("lw30 data", last_rd, 32'h11223344);
        access(1'b1, 1'b0, 3'b011, 32'h30, 32'd0, "l011");
        chk("l011 data", last_rd, 32'h11223344);
        access(1'b0, 1'b1, 3'b001, 32'h32, 32'h0000A5A5, "sh32");
        access(1'b1, 1'b0, 3'b010, 32'h30, 32'd0, "lw30b");
        chk("lw30b data", last_rd, 32'hA5A53344);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
